fp_topk_sel: RTL and testbench

FP_TOPK_SEL -- requirements
Module: fp_topk_sel

---
 rtl/fp_topk_sel.sv | 103 ++++++++++
 tb/tb_fp_topk_sel.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fp_topk_sel.sv
// Streaming K-nearest selector: keeps the K smallest distances, sorted ascending.
// One candidate per cycle; query framing via vld/last, restart via clr.
module fp_topk_sel #(
  parameter int DW = 32,
  parameter int IW = 16,
  parameter int K  = 4,
  localparam int CW = $clog2(K + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic            clr,
  input  logic            vld,
  input  logic            last,
  input  logic [DW-1:0]   d,
  input  logic [IW-1:0]   idx,
  output logic [K*DW-1:0] kd,
  output logic [K*IW-1:0] ki,
  output logic [CW-1:0]   cnt,
  output logic            done,
  output logic            busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]    st, st_n;
  logic [DW-1:0] dq [K];
  logic [IW-1:0] iq [K];
  logic [DW-1:0] db [K];
  logic [IW-1:0] ib [K];
  logic [DW-1:0] dn [K];
  logic [IW-1:0] in [K];
  logic [K-1:0]  lt;
  logic [CW-1:0] cb, cn;
  logic          fresh;

  // A new query in HOLD or a clr starts from an empty list.
  always_comb begin
    fresh = clr | ((st == S_HOLD) & vld);
    cb = fresh ? '0 : cnt;
    for (int i = 0; i < K; i++) begin
      db[i] = fresh ? '1 : dq[i];
      ib[i] = fresh ? '0 : iq[i];
      lt[i] = d < db[i];
    end
    dn = db;
    in = ib;
    cn = cb;
    // lt is a thermometer code: the list is sorted, so it rises once
    if (vld) begin
      if (lt[0]) begin
        dn[0] = d;
        in[0] = idx;
      end
      for (int i = 1; i < K; i++) begin
        if (lt[i]) begin
          dn[i] = lt[i-1] ? db[i-1] : d;
          in[i] = lt[i-1] ? ib[i-1] : idx;
        end
      end
      if ((lt != '0) && (cb != CW'(K)))
        cn = cb + 1'b1;
    end
  end

  always_comb begin
    st_n = st;
    if (vld)
      st_n = last ? S_HOLD : S_RUN;
    else if (clr || st == 2'd3)
      st_n = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= S_IDLE;
      cnt  <= '0;
      done <= 1'b0;
      busy <= 1'b0;
      for (int i = 0; i < K; i++) begin
        dq[i] <= '1;
        iq[i] <= '0;
      end
    end else if (ena) begin
      st   <= st_n;
      cnt  <= cn;
      done <= vld & last;
      busy <= (st_n == S_RUN);
      for (int i = 0; i < K; i++) begin
        dq[i] <= dn[i];
        iq[i] <= in[i];
      end
    end
  end

  for (genvar g = 0; g < K; g++) begin : g_out
    assign kd[g*DW +: DW] = dq[g];
    assign ki[g*IW +: IW] = iq[g];
  end

endmodule

// File: tb/tb_fp_topk_sel.sv
// Directed bench for fp_topk_sel with K=4, DW=32, IW=16.
// Expected lists are written slot 3 (MSB) down to slot 0.
module tb_fp_topk_sel;

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] F05  = 32'h3F00_0000;
  localparam logic [31:0] F1   = 32'h3F80_0000;
  localparam logic [31:0] F2   = 32'h4000_0000;
  localparam logic [31:0] F3   = 32'h4040_0000;
  localparam logic [31:0] F4   = 32'h4080_0000;
  localparam logic [31:0] F5   = 32'h40A0_0000;

  logic         clk = 1'b0;
  logic         rst, ena, clr, vld, last;
  logic [31:0]  d;
  logic [15:0]  idx;
  logic [127:0] kd;
  logic [63:0]  ki;
  logic [2:0]   cnt;
  logic         done, busy;

  int n_tests = 0;
  int n_fail  = 0;

  fp_topk_sel #(.DW(32), .IW(16), .K(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .clr(clr),
    .vld(vld), .last(last), .d(d), .idx(idx),
    .kd(kd), .ki(ki), .cnt(cnt), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic l,
                      input logic [31:0] dd, input logic [15:0] ii);
    vld = v; last = l; d = dd; idx = ii;
    @(posedge clk); #1;
    vld = 1'b0; last = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; clr = 1'b0;
    vld = 1'b0; last = 1'b0; d = '0; idx = '0;
    #12;
    check("rst_kd",   kd, {ONES, ONES, ONES, ONES});
    check("rst_ki",   ki, '0);
    check("rst_cnt",  cnt, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    ena = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // basic query, last on the fourth candidate
    step(1, 0, F3, 0);
    check("q1_cnt1",  cnt, 1);
    check("q1_busy",  busy, 1);
    step(1, 0, F1, 1);
    step(1, 0, F4, 2);
    check("q1_done0", done, 0);
    step(1, 1, F05, 3);
    check("q1_kd",   kd, {F4, F3, F1, F05});
    check("q1_ki",   ki, {16'd2, 16'd0, 16'd1, 16'd3});
    check("q1_cnt",  cnt, 4);
    check("q1_done", done, 1);
    check("q1_busy", busy, 0);
    step(0, 0, 0, 0);
    check("q1_once", done, 0);
    check("q1_hold", kd, {F4, F3, F1, F05});

    // refill in RUN, then insertion / tie / drop on a full list
    step(1, 0, F3, 0);
    check("q2_fresh", cnt, 1);
    step(1, 0, F1, 1);
    step(1, 0, F4, 2);
    step(1, 0, F05, 3);
    step(1, 0, F2, 9);
    check("ins_kd", kd, {F3, F2, F1, F05});
    check("ins_ki", ki, {16'd0, 16'd9, 16'd1, 16'd3});
    step(1, 0, F1, 7);
    check("tie_kd", kd, {F2, F1, F1, F05});
    check("tie_ki", ki, {16'd9, 16'd7, 16'd1, 16'd3});
    step(1, 0, F5, 8);
    check("drop_kd",  kd, {F2, F1, F1, F05});
    check("drop_ki",  ki, {16'd9, 16'd7, 16'd1, 16'd3});
    check("drop_cnt", cnt, 4);
    check("run_done", done, 0);

    // last without vld is ignored
    step(0, 1, F05, 5);
    check("lastnv_busy", busy, 1);
    check("lastnv_done", done, 0);

    // short query: two candidates
    clr = 1'b1;
    step(0, 0, 0, 0);
    clr = 1'b0;
    check("clr_cnt",  cnt, 0);
    check("clr_kd",   kd, {ONES, ONES, ONES, ONES});
    check("clr_busy", busy, 0);
    step(1, 0, F2, 5);
    step(1, 1, F1, 6);
    check("q3_cnt",  cnt, 2);
    check("q3_kd",   kd, {ONES, ONES, F2, F1});
    check("q3_ki",   ki, {16'd0, 16'd0, 16'd5, 16'd6});
    check("q3_done", done, 1);
    step(1, 0, F2, 4);
    check("q4_cnt",  cnt, 1);
    check("q4_kd",   kd, {ONES, ONES, ONES, F2});
    check("q4_done", done, 0);
    check("q4_busy", busy, 1);

    // enable low freezes everything
    ena = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 1, F05, 16'(i));
    check("ena_cnt",  cnt, 1);
    check("ena_kd",   kd, {ONES, ONES, ONES, F2});
    check("ena_done", done, 0);
    ena = 1'b1;

    // clr with simultaneous vld follows the IDLE rules
    clr = 1'b1;
    step(1, 0, F1, 2);
    clr = 1'b0;
    check("clrv_cnt",  cnt, 1);
    check("clrv_kd",   kd, {ONES, ONES, ONES, F1});
    check("clrv_ki",   ki, {16'd0, 16'd0, 16'd0, 16'd2});
    check("clrv_busy", busy, 1);

    // asynchronous reset mid-RUN
    clr = 1'b1;
    step(0, 0, 0, 0);
    clr = 1'b0;
    step(1, 0, F3, 1);
    step(1, 0, F4, 2);
    check("pre_rst_cnt", cnt, 2);
    #3;
    vld = 1'b1; last = 1'b1; d = F05; idx = 16'd3;
    rst = 1'b1;
    #1;
    check("arst_kd",   kd, {ONES, ONES, ONES, ONES});
    check("arst_ki",   ki, '0);
    check("arst_cnt",  cnt, 0);
    check("arst_busy", busy, 0);
    @(posedge clk); #1;
    check("arst_done", done, 0);
    vld = 1'b0; last = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      check("post_rst_done", done, 0);
    end
    check("post_rst_cnt", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
